// File: rtl/hqm_rcfwl_gclk_rcb_gate_ctrl.sv
// hqm_rcfwl_gclk_rcb_gate_ctrl: per-channel RCB enable sequencer with wake delay, idle hysteresis and LCP shadow config
module hqm_rcfwl_gclk_rcb_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int LCP_W    = 1,
    parameter int WAKE_DLY = 2,
    parameter int HYST_W   = 4
) (
    input  logic                    CkGridX1N,
    input  logic                    Rst,
    input  logic [NUM_CH-1:0]       ClkReq,
    input  logic                    ForceOn,
    input  logic [HYST_W-1:0]       HystCnt,
    input  logic                    CfgLoad,
    input  logic [NUM_CH*LCP_W-1:0] FdCfg,
    input  logic [NUM_CH*LCP_W-1:0] RdCfg,
    output logic [NUM_CH-1:0]       RcbEn,
    output logic [NUM_CH-1:0]       ClkAck,
    output logic [NUM_CH*LCP_W-1:0] FdOut,
    output logic [NUM_CH*LCP_W-1:0] RdOut,
    output logic [NUM_CH-1:0]       CfgPend
);
    localparam int WCW = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;

    typedef enum logic [1:0] {OFF, WAKE, ON, HYST} state_t;

    state_t                  state_q [NUM_CH];
    state_t                  state_d [NUM_CH];
    logic [WCW-1:0]          wcnt_q  [NUM_CH];
    logic [WCW-1:0]          wcnt_d  [NUM_CH];
    logic [HYST_W-1:0]       hcnt_q  [NUM_CH];
    logic [HYST_W-1:0]       hcnt_d  [NUM_CH];
    logic [NUM_CH-1:0]       req, apply;
    logic [NUM_CH-1:0]       en_q, en_d, ack_q, ack_d, pend_q, pend_d;
    logic [NUM_CH*LCP_W-1:0] fd_q, fd_d, rd_q, rd_d, sh_fd_q, sh_fd_d, sh_rd_q, sh_rd_d;

    assign req     = ClkReq | {NUM_CH{ForceOn}};
    assign RcbEn   = en_q;
    assign ClkAck  = ack_q;
    assign FdOut   = fd_q;
    assign RdOut   = rd_q;
    assign CfgPend = pend_q;

    // Per-channel gating FSM: wake countdown, idle hysteresis, registered enable/ack decode
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hcnt_d  = hcnt_q;
        en_d    = '0;
        ack_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (state_q[c])
                OFF: if (req[c]) begin
                    state_d[c] = WAKE;
                    wcnt_d[c]  = WCW'(WAKE_DLY - 1);
                end
                WAKE: if (wcnt_q[c] == '0) state_d[c] = ON;
                      else wcnt_d[c] = wcnt_q[c] - 1'b1;
                ON: if (!req[c]) begin
                    state_d[c] = (HystCnt != '0) ? HYST : OFF;
                    hcnt_d[c]  = (HystCnt != '0) ? HystCnt - 1'b1 : '0;
                end
                HYST: if (req[c]) state_d[c] = ON;
                      else if (hcnt_q[c] == '0) state_d[c] = OFF;
                      else hcnt_d[c] = hcnt_q[c] - 1'b1;
                default: state_d[c] = OFF;
            endcase
            en_d[c]  = state_d[c] != OFF;
            ack_d[c] = (state_d[c] == ON) || (state_d[c] == HYST);
        end
    end

    // Config shadow: apply only to idle, unrequested channels; a new load always re-arms pending
    always_comb begin
        fd_d    = fd_q;
        rd_d    = rd_q;
        apply   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            apply[c] = pend_q[c] && (state_q[c] == OFF) && !req[c];
            if (apply[c]) begin
                fd_d[c*LCP_W +: LCP_W] = sh_fd_q[c*LCP_W +: LCP_W];
                rd_d[c*LCP_W +: LCP_W] = sh_rd_q[c*LCP_W +: LCP_W];
            end
        end
        pend_d  = CfgLoad ? {NUM_CH{1'b1}} : (pend_q & ~apply);
        sh_fd_d = CfgLoad ? FdCfg : sh_fd_q;
        sh_rd_d = CfgLoad ? RdCfg : sh_rd_q;
    end

    // State and output registers; reset drops everything immediately
    always_ff @(posedge CkGridX1N) begin
        if (Rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= OFF;
                wcnt_q[c]  <= '0;
                hcnt_q[c]  <= '0;
            end
            en_q    <= '0;
            ack_q   <= '0;
            fd_q    <= '0;
            rd_q    <= '0;
            pend_q  <= '0;
            sh_fd_q <= '0;
            sh_rd_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            fd_q    <= fd_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            sh_fd_q <= sh_fd_d;
            sh_rd_q <= sh_rd_d;
        end
    end
endmodule

// File: tb/tb_hqm_rcfwl_gclk_rcb_gate_ctrl.sv
// tb_hqm_rcfwl_gclk_rcb_gate_ctrl: directed scoreboard bench for the RCB gate controller
module tb_hqm_rcfwl_gclk_rcb_gate_ctrl;
    logic       clk = 1'b0;
    logic       Rst;
    logic [3:0] ClkReq;
    logic       ForceOn;
    logic [3:0] HystCnt;
    logic       CfgLoad;
    logic [3:0] FdCfg, RdCfg;
    logic [3:0] RcbEn, ClkAck, FdOut, RdOut, CfgPend;

    typedef struct {
        string      tag;
        logic [3:0] en, ack, fd, rd, pend;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    hqm_rcfwl_gclk_rcb_gate_ctrl #(.NUM_CH(4), .LCP_W(1), .WAKE_DLY(2), .HYST_W(4)) dut (
        .CkGridX1N(clk),
        .Rst(Rst),
        .ClkReq(ClkReq),
        .ForceOn(ForceOn),
        .HystCnt(HystCnt),
        .CfgLoad(CfgLoad),
        .FdCfg(FdCfg),
        .RdCfg(RdCfg),
        .RcbEn(RcbEn),
        .ClkAck(ClkAck),
        .FdOut(FdOut),
        .RdOut(RdOut),
        .CfgPend(CfgPend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string nm, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, nm, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [3:0] req, input logic frc,
                        input logic [3:0] hy, input logic ld, input logic [3:0] fd, input logic [3:0] rd,
                        input logic [3:0] e_en, input logic [3:0] e_ack, input logic [3:0] e_fd,
                        input logic [3:0] e_rd, input logic [3:0] e_pend);
        exp_t e;
        Rst = rst; ClkReq = req; ForceOn = frc; HystCnt = hy; CfgLoad = ld; FdCfg = fd; RdCfg = rd;
        sb.push_back('{tag, e_en, e_ack, e_fd, e_rd, e_pend});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "RcbEn", RcbEn, e.en);
        chk(e.tag, "ClkAck", ClkAck, e.ack);
        chk(e.tag, "FdOut", FdOut, e.fd);
        chk(e.tag, "RdOut", RdOut, e.rd);
        chk(e.tag, "CfgPend", CfgPend, e.pend);
    endtask

    initial begin
        #1;
        //   tag         rst req     frc hyst   ld fdcfg   rdcfg    en      ack     fd      rd      pend
        step("rst0",     1, 4'b0000, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("rst1",     1, 4'b0000, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("wake0",    0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("wake1",    0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("on0",      0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("hy3_a",    0, 4'b0000, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("hy3_b",    0, 4'b0000, 0, 4'd9, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("hy3_c",    0, 4'b0000, 0, 4'd9, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("hy3_off",  0, 4'b0000, 0, 4'd9, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("w2_a",     0, 4'b0001, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("w2_b",     0, 4'b0001, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("w2_on",    0, 4'b0001, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("hy0_off",  0, 4'b0000, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("w3_a",     0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("w3_b",     0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("w3_on",    0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("rq_hy2",   0, 4'b0000, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("rq_hy1",   0, 4'b0000, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("rq_back",  0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("rq_stay",  0, 4'b0001, 0, 4'd3, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("rq_off",   0, 4'b0000, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("c_wk_a",   0, 4'b1110, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("c_wk_b",   0, 4'b1110, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("c_on",     0, 4'b1110, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
        step("c_load",   0, 4'b1110, 0, 4'd0, 1, 4'b1010, 4'b0101, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b1111);
        step("c_ap0",    0, 4'b1110, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 4'b0000, 4'b0001, 4'b1110);
        step("c_ch1off", 0, 4'b1100, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b0001, 4'b1110);
        step("c_ap1",    0, 4'b1100, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0010, 4'b0001, 4'b1100);
        step("rst_mid",  1, 4'b1100, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("f_wk_a",   0, 4'b0000, 1, 4'd2, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("f_wk_b",   0, 4'b0000, 1, 4'd2, 0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("f_on",     0, 4'b0000, 1, 4'd2, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step("f_hy_a",   0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step("f_hy_b",   0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step("f_off",    0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("p_wk_a",   0, 4'b0100, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("p_wk_b",   0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("p_on",     0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        step("p_hy_a",   0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        step("p_hy_b",   0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        step("p_off",    0, 4'b0000, 0, 4'd2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("h0_wk_a",  0, 4'b0001, 0, 4'd1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("h0_wk_b",  0, 4'b0001, 0, 4'd1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("h0_on",    0, 4'b0001, 0, 4'd1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("h0_hy",    0, 4'b0000, 0, 4'd1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("h0_keep",  0, 4'b0001, 0, 4'd1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step("h0_off",   0, 4'b0000, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("l_first",  0, 4'b0000, 0, 4'd0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        step("l_wins",   0, 4'b0000, 0, 4'd0, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
        step("l_apply",  0, 4'b0000, 0, 4'd0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hqm_rcfwl_gclk_rcb_gate_ctrl.md
Name: hqm_rcfwl_gclk_rcb_gate_ctrl

Overview:
Multi-channel regional clock buffer controller. It sequences per-channel RCB enables from synchronous clock requests, using a programmable wake delay and an idle hysteresis. It also manages the per-channel LCP (Fd/Rd) bits so they only change while a channel's RCB is off. It sits ahead of an array of ctech RCB-and cells, driving their en/fd/rd pins, and generalises the single free-running RCB instance to NUM_CH gated channels.

Parameters:
NUM_CH, 4, number of RCB channels (>=1)
LCP_W, 1, width of each channel's Fd and Rd field
WAKE_DLY, 2, cycles from RcbEn rise to ClkAck rise (>=1)
HYST_W, 4, width of idle hysteresis count

Ports:
CkGridX1N  in  1  grid clock; all logic on its rising edge
Rst  in  1  synchronous reset, active-high
ClkReq  in  NUM_CH  per-channel clock request, synchronous to CkGridX1N
ForceOn  in  1  test override; acts as ClkReq on every channel
HystCnt  in  HYST_W  idle cycles before gating; sampled on ON->HYST entry
CfgLoad  in  1  one-cycle pulse; captures FdCfg/RdCfg into shadow
FdCfg  in  NUM_CH*LCP_W  new Fd values, channel i at [i*LCP_W +: LCP_W]
RdCfg  in  NUM_CH*LCP_W  new Rd values, same packing
RcbEn  out  NUM_CH  RCB enable per channel
ClkAck  out  NUM_CH  clock stable/usable per channel
FdOut  out  NUM_CH*LCP_W  applied Fd per channel
RdOut  out  NUM_CH*LCP_W  applied Rd per channel
CfgPend  out  NUM_CH  shadow config not yet applied to channel

Behaviour:
- Reset (Rst=1 at an edge): every channel goes to OFF. RcbEn=0, ClkAck=0, FdOut=0, RdOut=0, CfgPend=0, shadow=0, counters=0. Reset asserted mid-operation drops RcbEn/ClkAck on that edge, with no hysteresis.
- All outputs are registered. Channels are independent. Define req_i = ClkReq[i] | ForceOn.
- Per-channel FSM, with outputs shown as (RcbEn, ClkAck):
  - OFF (0,0): if req_i, go to WAKE and load wcnt=WAKE_DLY-1.
  - WAKE (1,0): if wcnt==0, go to ON; else wcnt--. The request is not sampled in WAKE; a drop does not abort the wake.
  - ON (1,1): if !req_i, go to HYST when HystCnt!=0 (load hcnt=HystCnt-1), or directly to OFF when HystCnt==0.
  - HYST (1,1): if req_i, go to ON (no wake penalty). Else if hcnt==0, go to OFF. Else hcnt--.
  - Changes to HystCnt during HYST are ignored.
- Latency: req rises, sampled at edge N -> RcbEn=1 after edge N, ClkAck=1 after edge N+WAKE_DLY.
- Gating latency: req falls, sampled at edge M -> RcbEn/ClkAck=0 after edge M+HystCnt (after edge M if HystCnt=0). A request in the same cycle hcnt==0 keeps the channel ON.
- ClkAck never rises without RcbEn already high for WAKE_DLY cycles. RcbEn never falls while ClkAck is high except in the OFF transition (both fall on the same edge).
- Config shadow:
  - CfgLoad=1 writes FdCfg/RdCfg to the shadow and sets all CfgPend bits.
  - Channel i applies its shadow to FdOut/RdOut on an edge where it is in OFF and !req_i; that edge clears CfgPend[i].
  - CfgLoad in the same cycle as an apply: the apply uses the old shadow, the new shadow is written, and CfgPend[i] stays 1 (load wins).
  - FdOut/RdOut never change while RcbEn[i]=1 or on the edge RcbEn[i] rises.
- ForceOn is held through every channel's WAKE; releasing it follows the normal HYST path.
- Counters are WAKE_DLY-sized (clog2, min 1 bit) and HYST_W wide. There is no wrap: counts stop at 0.

Test Plan:
- Reset, then ClkReq[0] 0->1 with WAKE_DLY=2 -> RcbEn[0]=1 one cycle later, ClkAck[0]=1 two cycles after that; other channels stay 0.
- ON channel, HystCnt=3, drop ClkReq -> RcbEn/ClkAck stay 1 for 3 cycles then 0. Repeat with HystCnt=0 -> both fall on the next edge.
- In HYST with hcnt=1, reassert ClkReq -> channel returns to ON, ClkAck never drops, no WAKE delay.
- CfgLoad with FdCfg=4'b1010 while ch1 ON and ch0 OFF -> FdOut[0]=0 next cycle, CfgPend=4'b1110. ch1 applies only after it reaches OFF, then CfgPend[1]=0.
- ForceOn=1 with ClkReq=0 -> all RcbEn rise together, all ClkAck after WAKE_DLY. Rst pulse mid-ON -> all outputs 0 on that edge, and config is restored to 0.
- ClkReq pulse of 1 cycle during OFF -> full WAKE completes, ClkAck high 1 cycle in ON, then HYST for HystCnt cycles, then OFF.
